// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared types for the bit-serial adder sequencer
// Purpose: sequencer state encoding, shared by the controller and its bench.
// Ports:   none (package).
`timescale 1ns/1ps
package serial_adder_ctrl_pkg;

  // S_IDLE doubles as the default / recovery state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// rtl/serial_adder_ctrl_fa.sv - one-bit full adder cell shared by the serial adder
// Purpose: combinational 1-bit full adder; the only adder logic in the block.
// Ports:   a, b - operand bits; c - carry in
//          out  - sum bit;      cy - carry out
`timescale 1ns/1ps
module serial_adder_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic out,
  output logic cy
);

  assign out = a ^ b ^ c;
  assign cy  = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer around one full adder cell
// Purpose: adds two WIDTH-bit operands LSB first, one bit per clock, reusing a
//          single full adder cell with a registered carry fed back each cycle.
// Ports:   clk, rst_n    - clock, asynchronous active-low reset
//          start         - request, sampled only while idle
//          a, b, cin     - operands and carry-in, captured on the accepted start
//          busy          - high whenever the sequencer is not idle
//          done          - one-cycle pulse when sum/cout are valid
//          sum, cout     - a + b + cin modulo 2^WIDTH, and carry out of the MSB
`timescale 1ns/1ps
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             fa_out;
  logic             fa_cy;

  serial_adder_ctrl_fa u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .c   (carry),
    .out (fa_out),
    .cy  (fa_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (cnt == LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      done_q <= 1'b0;
    end else begin
      // done is registered off the next-state so it lines up exactly with DONE.
      done_q <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        S_RUN: begin
          // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands at sum[0].
          sum   <= {fa_out, sum[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cy;
          // Hold at the last index so the counter never wraps mid-operation.
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for the bit-serial adder sequencer
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           compared   = 0;
  int           mismatched = 0;
  logic [W:0]   exp_q[$];
  int           rem        = 0;
  logic         final_req  = 1'b0;
  logic         final_done = 1'b0;
  logic [W-1:0] last_sum   = '0;
  logic         last_cout  = 1'b0;
  logic [W:0]   e;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Reference model: an accepted op occupies W+2 cycles in total; the result is
  // plain integer addition. rem counts cycles left until the block is idle again.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0;
      exp_q.delete();
    end else if (rem > 0) begin
      rem = rem - 1;
    end else if (start) begin
      exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
      rem = W + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: checks every cycle away from the active edge, plus right after an
  // asynchronous reset assertion.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum",  {56'd0, sum},  64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        last_sum  = '0;
        last_cout = 1'b0;
      end else begin
        chk("busy", {63'd0, busy}, {63'd0, (rem > 0)});
        chk("done", {63'd0, done}, {63'd0, (rem == 1)});
        if (done) begin
          chk("result_pending", {63'd0, (exp_q.size() != 0)}, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sum",  {56'd0, sum},  {56'd0, e[W-1:0]});
            chk("cout", {63'd0, cout}, {63'd0, e[W]});
            last_sum  = e[W-1:0];
            last_cout = e[W];
          end
        end else if (rem == 0) begin
          chk("hold_sum",  {56'd0, sum},  {56'd0, last_sum});
          chk("hold_cout", {63'd0, cout}, {63'd0, last_cout});
        end
      end
      if (final_req && !final_done) begin
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(W + 2);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    op(8'h0F, 8'h01, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);

    // Second start mid-run must be ignored.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    a = 8'h01; b = 8'h01; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(W);

    // Reset mid-operation, then a fresh op.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    op(8'h55, 8'hAA, 1'b0);

    // start held high, operands changing every cycle.
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      cyc(1);
    end
    start = 1'b0;
    cyc(W + 3);

    // Random sparse starts.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      cyc(1);
    end
    start = 1'b0;
    cyc(W + 3);

    final_req = 1'b1;
    for (int i = 0; i < 5 && !final_done; i++) cyc(1);
    if (!final_done) $display("FAIL final_check: actual=pending required=complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
